multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control FSM for a multicycle MIPS-style datapath (RESET, FETCH,
//   DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, IMMEX, IMMWB, BRANCH,
//   JUMP, HALT).
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   instr[31:0]           IR contents (opcode [31:26], funct [5:0])
//   zero                  ALU zero flag; the PC load gate outside this block
//                         uses it together with pc_write_cond/invertzero
//   mem_ready             memory handshake, access completes when 1
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write
//   regdst[1:0]           0 rt, 1 rd, 2 $31
//   memtoreg[1:0]         0 ALU, 1 memory, 2 PC+4
//   regwrite, alusrc_a, invertzero
//   alusrc_b[1:0]         0 rt, 1 const 4, 2 simm, 3 simm<<2
//   aluop[3:0]            ALU_* encoding
//   pc_source[1:0]        0 ALU, 1 ALU register, 2 jump address
//   state[3:0]            current state (debug)
//   halted, illegal       sticky status flags (cleared only by reset)
module multicycle_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  regdst,
  output logic [1:0]  memtoreg,
  output logic        regwrite,
  output logic        alusrc_a,
  output logic        invertzero,
  output logic [1:0]  alusrc_b,
  output logic [3:0]  aluop,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_RWB    = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_BRANCH = 4'd11,
    S_JUMP   = 4'd12, S_HALT   = 4'd13
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic       w_rtype_ok;
  logic       w_decode_illegal;
  logic       w_unused;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_rtype_ok = (w_opcode == OP_RTYPE) &&
                      (w_funct == FN_ADD || w_funct == FN_SUB || w_funct == FN_AND ||
                       w_funct == FN_OR  || w_funct == FN_SLT);

  // zero only feeds the external PC-load gate; register fields are datapath-only
  assign w_unused = &{1'b0, zero, instr[25:6]};

  // instr==0 halts cleanly; everything else DECODE can't dispatch is illegal
  assign w_decode_illegal = (r_state == S_DECODE) && (w_next == S_HALT) && (instr != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_RESET;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_decode_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:  w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (instr == '0)                                 w_next = S_HALT;
        else if (w_opcode == OP_LW || w_opcode == OP_SW) w_next = S_MEMADR;
        else if (w_rtype_ok)                             w_next = S_EXEC;
        else if (w_opcode == OP_ADDI || w_opcode == OP_ORI) w_next = S_IMMEX;
        else if (w_opcode == OP_BEQ || w_opcode == OP_BNE)  w_next = S_BRANCH;
        else if (w_opcode == OP_J || w_opcode == OP_JAL)    w_next = S_JUMP;
        else                                             w_next = S_HALT;
      end
      S_MEMADR: w_next = (w_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      // write-back is held off until mem_ready so regwrite pulses exactly once
      S_MEMWB:  if (mem_ready) w_next = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_EXEC:   w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_IMMEX:  w_next = S_IMMWB;
      S_IMMWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_RESET;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    regdst        = 2'd0;
    memtoreg      = 2'd0;
    regwrite      = 1'b0;
    alusrc_a      = 1'b0;
    invertzero    = 1'b0;
    alusrc_b      = 2'd0;
    aluop         = 4'd0;
    pc_source     = 2'd0;
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        alusrc_b = 2'd1;
        aluop    = ALU_ADD;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        alusrc_b = 2'd3;
        aluop    = ALU_ADD;
      end
      S_MEMADR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'd2;
        aluop    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 2'd1;
        regwrite = mem_ready;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alusrc_a = 1'b1;
        case (w_funct)
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SUB:  aluop = ALU_SUB;
          FN_SLT:  aluop = ALU_SLT;
          default: aluop = ALU_ADD;
        endcase
      end
      S_RWB: begin
        regdst   = 2'd1;
        regwrite = 1'b1;
      end
      S_IMMEX: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'd2;
        aluop    = (w_opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IMMWB: regwrite = 1'b1;
      S_BRANCH: begin
        alusrc_a      = 1'b1;
        aluop         = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        invertzero    = (w_opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        if (w_opcode == OP_JAL) begin
          regwrite = 1'b1;
          regdst   = 2'd2;
          memtoreg = 2'd2;
        end
      end
      default: ;
    endcase
    halted  = (r_state == S_HALT);
    illegal = r_illegal;
    state   = r_state;
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic [1:0]  regdst, memtoreg;
  logic        regwrite, alusrc_a, invertzero;
  logic [1:0]  alusrc_b;
  logic [3:0]  aluop;
  logic [1:0]  pc_source;
  logic [3:0]  state;
  logic        halted, illegal;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrc_a(alusrc_a), .invertzero(invertzero), .alusrc_b(alusrc_b),
    .aluop(aluop), .pc_source(pc_source), .state(state),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam int S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4,
                 S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_RWB = 8, S_IMMEX = 9,
                 S_IMMWB = 10, S_BRANCH = 11, S_JUMP = 12, S_HALT = 13;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SUB = 4'b0110, A_SLT = 4'b0111;
  localparam int C_HALT0 = 0, C_LW = 1, C_SW = 2, C_R = 3, C_IMM = 4,
                 C_BR = 5, C_J = 6, C_ILL = 7;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic [1:0] regdst, memtoreg;
    logic       regwrite, alusrc_a, invertzero;
    logic [1:0] alusrc_b;
    logic [3:0] aluop;
    logic [1:0] pc_source;
    logic       halted, illegal;
  } outs_t;

  int errors = 0;
  int checks = 0;
  int path[$];
  int n_irw, n_rw, n_pcw, n_pcl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic outs_t observed();
    outs_t o;
    o = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, regdst, memtoreg,
         regwrite, alusrc_a, invertzero, alusrc_b, aluop, pc_source, halted, illegal};
    return o;
  endfunction

  function automatic int iclass(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (ins == 32'h0) return C_HALT0;
    case (op)
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h00: return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                     fn == 6'h25 || fn == 6'h2A) ? C_R : C_ILL;
      6'h08, 6'h0D: return C_IMM;
      6'h04, 6'h05: return C_BR;
      6'h02, 6'h03: return C_J;
      default: return C_ILL;
    endcase
  endfunction

  task automatic build_path(input logic [31:0] ins);
    path = '{S_FETCH, S_DECODE};
    case (iclass(ins))
      C_LW:    begin path.push_back(S_MEMADR); path.push_back(S_MEMRD); path.push_back(S_MEMWB); end
      C_SW:    begin path.push_back(S_MEMADR); path.push_back(S_MEMWR); end
      C_R:     begin path.push_back(S_EXEC);   path.push_back(S_RWB); end
      C_IMM:   begin path.push_back(S_IMMEX);  path.push_back(S_IMMWB); end
      C_BR:    path.push_back(S_BRANCH);
      C_J:     path.push_back(S_JUMP);
      default: path.push_back(S_HALT);
    endcase
  endtask

  // expected control word for a state, from the per-state output table
  function automatic outs_t expect_outs(input int st, input logic [31:0] ins, input logic mr);
    outs_t o;
    logic [5:0] op, fn;
    o  = '0;
    op = ins[31:26];
    fn = ins[5:0];
    case (st)
      S_FETCH:  begin o.mem_read = 1; o.alusrc_b = 1; o.aluop = A_ADD; o.ir_write = mr; o.pc_write = mr; end
      S_DECODE: begin o.alusrc_b = 3; o.aluop = A_ADD; end
      S_MEMADR: begin o.alusrc_a = 1; o.alusrc_b = 2; o.aluop = A_ADD; end
      S_MEMRD:  begin o.mem_read = 1; o.iord = 1; end
      S_MEMWB:  begin o.memtoreg = 1; o.regwrite = mr; end
      S_MEMWR:  begin o.mem_write = 1; o.iord = 1; end
      S_EXEC: begin
        o.alusrc_a = 1;
        o.aluop = (fn == 6'h24) ? A_AND : (fn == 6'h25) ? A_OR : (fn == 6'h22) ? A_SUB :
                  (fn == 6'h2A) ? A_SLT : A_ADD;
      end
      S_RWB:    begin o.regdst = 1; o.regwrite = 1; end
      S_IMMEX:  begin o.alusrc_a = 1; o.alusrc_b = 2; o.aluop = (op == 6'h0D) ? A_OR : A_ADD; end
      S_IMMWB:  o.regwrite = 1;
      S_BRANCH: begin
        o.alusrc_a = 1; o.aluop = A_SUB; o.pc_write_cond = 1; o.pc_source = 1;
        o.invertzero = (op == 6'h05);
      end
      S_JUMP: begin
        o.pc_write = 1; o.pc_source = 2;
        if (op == 6'h03) begin o.regwrite = 1; o.regdst = 2; o.memtoreg = 2; end
      end
      S_HALT: begin o.halted = 1; o.illegal = (iclass(ins) == C_ILL); end
      default: ;
    endcase
    return o;
  endfunction

  // Asynchronous reset mid-cycle, then release and confirm FETCH one edge later.
  task automatic abort_reset(input string tag);
    #1 reset_n = 1'b0;
    #1;
    check({tag, "_rst_state"}, 32'(state), S_RESET);
    check({tag, "_rst_outs"}, 32'(observed()), 32'(expect_outs(S_RESET, instr, mem_ready)));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check({tag, "_rel_state"}, 32'(state), S_RESET);
    @(posedge clk); #1;
    check({tag, "_first_fetch"}, 32'(state), S_FETCH);
  endtask

  // mode 0: random mem_ready, 1: always ready, 2: two waits in FETCH and MEMRD.
  // abort_st >= 0: reset is pulsed during the first wait cycle of that state.
  task automatic run_instr(input logic [31:0] ins, input int mode, input logic z, input int abort_st);
    int st, w;
    logic mr, waitable;
    build_path(ins);
    instr = ins;
    zero  = z;
    n_irw = 0; n_rw = 0; n_pcw = 0; n_pcl = 0;
    foreach (path[i]) begin
      st = path[i];
      w  = 0;
      forever begin
        waitable = (st == S_FETCH || st == S_MEMRD || st == S_MEMWR);
        if (st == abort_st)  mr = 1'b0;
        else if (!waitable)  mr = (st == S_MEMWB) ? 1'b1 : 1'($urandom_range(0, 1));
        else if (mode == 1)  mr = 1'b1;
        else if (mode == 2)  mr = (st == S_MEMWR) ? 1'b1 : (w >= 2);
        else                 mr = ($urandom_range(0, 2) != 0) || (w >= 4);
        mem_ready = mr;
        @(negedge clk);
        check($sformatf("state_in_st%0d", st), 32'(state), st);
        check($sformatf("outs_in_st%0d", st), 32'(observed()), 32'(expect_outs(st, ins, mr)));
        n_irw += int'(ir_write);
        n_rw  += int'(regwrite);
        n_pcw += int'(pc_write);
        n_pcl += int'(pc_write_cond & (zero ^ invertzero));
        if (st == abort_st) begin
          abort_reset($sformatf("abort_st%0d", st));
          return;
        end
        @(posedge clk); #1;
        if (!waitable || mr) break;
        w++;
      end
    end
  endtask

  task automatic hold_halt(input logic [31:0] ins, input string tag);
    logic mr;
    for (int i = 0; i < 4; i++) begin
      mr = 1'($urandom_range(0, 1));
      mem_ready = mr;
      @(negedge clk);
      check({tag, "_hold_state"}, 32'(state), S_HALT);
      check({tag, "_hold_outs"}, 32'(observed()), 32'(expect_outs(S_HALT, ins, mr)));
      @(posedge clk); #1;
    end
    abort_reset(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    r = $urandom();
    case ($urandom_range(0, 9))
      0:       return {6'h23, r[25:0]};
      1:       return {6'h2B, r[25:0]};
      2, 9:    return {6'h00, r[25:6], fns[$urandom_range(0, 4)]};
      3:       return {6'h08, r[25:0]};
      4:       return {6'h0D, r[25:0]};
      5:       return {6'h04, r[25:0]};
      6:       return {6'h05, r[25:0]};
      7:       return {6'h02, r[25:0]};
      default: return {6'h03, r[25:0]};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    instr     = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("reset_state", 32'(state), S_RESET);
    check("reset_outs", 32'(observed()), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("release_state", 32'(state), S_RESET);
    @(posedge clk); #1;

    // ADD $3,$1,$2 with no wait states
    run_instr(32'h0022_1820, 1, 1'b0, -1);
    check("add_regwrite_pulses", n_rw, 1);
    check("add_pcwrite_pulses", n_pcw, 1);

    // LW with two waits in FETCH and in MEMRD
    run_instr({6'h23, 5'd1, 5'd2, 16'h0010}, 2, 1'b0, -1);
    check("lw_irwrite_pulses", n_irw, 1);
    check("lw_regwrite_pulses", n_rw, 1);

    // BNE with zero=1: no PC load; BEQ with zero=1: PC load
    run_instr({6'h05, 5'd1, 5'd2, 16'hFFFE}, 1, 1'b1, -1);
    check("bne_pc_load", n_pcl, 0);
    run_instr({6'h04, 5'd1, 5'd2, 16'h0003}, 1, 1'b1, -1);
    check("beq_pc_load", n_pcl, 1);

    run_instr({6'h03, 26'h0100010}, 1, 1'b0, -1);
    check("jal_pcwrite_pulses", n_pcw, 2);

    for (int i = 0; i < 40; i++)
      run_instr(rand_instr(), 0, 1'($urandom_range(0, 1)), -1);

    // reset mid-MEMWR and mid-FETCH wait: strobes drop, no write pulses
    run_instr({6'h2B, 5'd4, 5'd5, 16'h0020}, 1, 1'b0, S_MEMWR);
    run_instr({6'h23, 5'd4, 5'd5, 16'h0020}, 1, 1'b0, S_FETCH);
    check("abort_fetch_no_irwrite", n_irw, 0);
    run_instr({6'h23, 5'd4, 5'd5, 16'h0020}, 1, 1'b0, S_MEMRD);
    check("abort_memrd_no_regwrite", n_rw, 0);

    run_instr(32'h0000_0000, 0, 1'b0, -1);
    hold_halt(32'h0000_0000, "halt_zero");
    run_instr(32'hFC00_0000, 0, 1'b0, -1);
    hold_halt(32'hFC00_0000, "halt_op3f");
    run_instr(32'h0022_1827, 0, 1'b0, -1);
    hold_halt(32'h0022_1827, "halt_badfunct");

    run_instr(32'h0022_182A, 1, 1'b0, -1);
    check("post_halt_slt_regwrite", n_rw, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
